// File: rtl/framer_pkg.sv
// Shared types, sizes and small helpers for the window deframer: frame sizes,
// state enum, sample type and the rounded average used when overlapping frames.
package framer_pkg;

  localparam int FRAME_SIZE_128 = 128;
  localparam int FRAME_SIZE_256 = 256;

  typedef enum logic {
    RECV = 1'b0,
    EMIT = 1'b1
  } deframer_state_e;

  typedef logic [7:0] sample_t;

  function automatic logic [7:0] frame_last_idx(input logic n256);
    return n256 ? 8'(FRAME_SIZE_256 - 1) : 8'(FRAME_SIZE_128 - 1);
  endfunction

  function automatic logic [7:0] hop_size(input logic n256);
    return n256 ? 8'(FRAME_SIZE_256 / 2) : 8'(FRAME_SIZE_128 / 2);
  endfunction

  function automatic logic [7:0] emit_last_idx(input logic n256, input logic ovl);
    return ovl ? (hop_size(n256) - 8'd1) : frame_last_idx(n256);
  endfunction

  // 9-bit sum so 0xFF + 0xFF + 1 does not wrap before the halving.
  function automatic sample_t avg_round(input sample_t a, input sample_t b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
    return 8'(sum >> 1);
  endfunction

endpackage

// File: rtl/frame_sram.sv
// 256x8 frame buffer: one synchronous write port, two asynchronous read ports
// (current sample index and the matching second-half index for the tail).
module frame_sram
  import framer_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  sample_t    wdata,
  input  logic [7:0] raddr_a,
  output sample_t    rdata_a,
  input  logic [7:0] raddr_b,
  output sample_t    rdata_b
);

  sample_t mem_q [256];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/window_deframer.sv
// Collects N-byte frames and replays them, either verbatim or as an overlap-add
// of the first half with the previous frame's second half (rounded average).
module window_deframer
  import framer_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            use_256_points,
  input  logic            overlap_half_window,
  input  logic            flush,
  input  logic            window_valid,
  input  logic [7:0]      window_data,
  output logic            window_ready,
  output logic            sample_valid,
  output logic [7:0]      sample_data,
  input  logic            sample_ready,
  output logic            frame_done,
  output logic [7:0]      frame_count,
  output deframer_state_e dbg_state
);

  // Handshake: a byte/sample moves only in a cycle where valid and ready are both 1;
  // the sample side is registered and holds while sample_valid=1 and sample_ready=0.

  deframer_state_e state_q, state_d;
  logic [7:0] wr_idx_q, wr_idx_d;
  logic [7:0] rd_idx_q, rd_idx_d;
  logic       tail_valid_q, tail_valid_d;
  logic       n256_q, n256_d;
  logic       ovl_q, ovl_d;
  logic       sample_valid_q, sample_valid_d;
  sample_t    sample_data_q, sample_data_d;
  logic       frame_done_q, frame_done_d;
  logic [7:0] frame_count_q, frame_count_d;

  logic       sram_we;
  logic [7:0] rd_a_addr;
  logic [7:0] rd_b_addr;
  sample_t    sram_rd_a;
  sample_t    sram_rd_b;
  logic       tail_we;
  sample_t    tail_q [128];
  sample_t    tail_rd;
  sample_t    next_sample;

  frame_sram u_frame_sram (
    .clk     (clk),
    .we      (sram_we),
    .waddr   (wr_idx_q),
    .wdata   (window_data),
    .raddr_a (rd_a_addr),
    .rdata_a (sram_rd_a),
    .raddr_b (rd_b_addr),
    .rdata_b (sram_rd_b)
  );

  // Port A always points at the sample to load next: index 0 while receiving,
  // the following index while emitting. Port B feeds the tail refill.
  assign rd_a_addr = (state_q == EMIT) ? (rd_idx_q + 8'd1) : 8'd0;
  assign rd_b_addr = hop_size(n256_q) + rd_idx_q;
  assign tail_rd   = tail_q[rd_a_addr[6:0]];

  always_ff @(posedge clk) begin
    if (tail_we) begin
      tail_q[rd_idx_q[6:0]] <= sram_rd_b;
    end
  end

  always_comb begin
    next_sample = (ovl_q && tail_valid_q) ? avg_round(tail_rd, sram_rd_a) : sram_rd_a;
  end

  always_comb begin
    state_d        = state_q;
    wr_idx_d       = wr_idx_q;
    rd_idx_d       = rd_idx_q;
    tail_valid_d   = tail_valid_q;
    n256_d         = n256_q;
    ovl_d          = ovl_q;
    sample_valid_d = sample_valid_q;
    sample_data_d  = sample_data_q;
    frame_done_d   = 1'b0;
    frame_count_d  = frame_count_q;
    sram_we        = 1'b0;
    tail_we        = 1'b0;

    case (state_q)
      RECV: begin
        if (flush) begin
          wr_idx_d     = 8'd0;
          tail_valid_d = 1'b0;
        end else if (window_valid) begin
          sram_we  = 1'b1;
          wr_idx_d = wr_idx_q + 8'd1;
          if (wr_idx_q == 8'd0) begin
            n256_d = use_256_points;
            ovl_d  = overlap_half_window;
            // History from a differently shaped or non-overlap frame is unusable.
            if (!overlap_half_window || (use_256_points != n256_q) ||
                (overlap_half_window != ovl_q)) begin
              tail_valid_d = 1'b0;
            end
          end else if (wr_idx_q == frame_last_idx(n256_q)) begin
            state_d        = EMIT;
            rd_idx_d       = 8'd0;
            sample_valid_d = 1'b1;
            sample_data_d  = next_sample;
          end
        end
      end

      EMIT: begin
        if (sample_ready) begin
          tail_we = ovl_q;
          if (rd_idx_q == emit_last_idx(n256_q, ovl_q)) begin
            state_d        = RECV;
            sample_valid_d = 1'b0;
            frame_done_d   = 1'b1;
            frame_count_d  = frame_count_q + 8'd1;
            wr_idx_d       = 8'd0;
            rd_idx_d       = 8'd0;
            tail_valid_d   = ovl_q;
          end else begin
            rd_idx_d      = rd_idx_q + 8'd1;
            sample_data_d = next_sample;
          end
        end
      end

      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RECV;
      wr_idx_q       <= 8'd0;
      rd_idx_q       <= 8'd0;
      tail_valid_q   <= 1'b0;
      n256_q         <= 1'b0;
      ovl_q          <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_data_q  <= 8'd0;
      frame_done_q   <= 1'b0;
      frame_count_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      wr_idx_q       <= wr_idx_d;
      rd_idx_q       <= rd_idx_d;
      tail_valid_q   <= tail_valid_d;
      n256_q         <= n256_d;
      ovl_q          <= ovl_d;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
      frame_done_q   <= frame_done_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign window_ready = (state_q == RECV);
  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_window_deframer.sv
// Directed bench for window_deframer: hand-computed frames, an expected-sample
// queue drained by a negedge monitor, and a single pass/total summary.
module tb_window_deframer;
  import framer_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            use_256_points;
  logic            overlap_half_window;
  logic            flush;
  logic            window_valid;
  logic [7:0]      window_data;
  logic            window_ready;
  logic            sample_valid;
  logic [7:0]      sample_data;
  logic            sample_ready;
  logic            frame_done;
  logic [7:0]      frame_count;
  deframer_state_e dbg_state;

  logic [7:0] exp_q[$];
  logic [7:0] byte_arr [256];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         done_cnt = 0;

  window_deframer dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .use_256_points      (use_256_points),
    .overlap_half_window (overlap_half_window),
    .flush               (flush),
    .window_valid        (window_valid),
    .window_data         (window_data),
    .window_ready        (window_ready),
    .sample_valid        (sample_valid),
    .sample_data         (sample_data),
    .sample_ready        (sample_ready),
    .frame_done          (frame_done),
    .frame_count         (frame_count),
    .dbg_state           (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Scoreboard: every accepted sample is compared against the expected queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_sample", 32'(exp_q.size()), 32'd1);
        end else begin
          check("sample", 32'(sample_data), 32'(exp_q.pop_front()));
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pattern(input int mode, input int i, input logic [7:0] v);
    case (mode)
      0:       return v;
      1:       return 8'(i);
      2:       return 8'(255 - i);
      default: return 8'(i * 3);
    endcase
  endfunction

  task automatic fill(input int count, input int mode, input logic [7:0] v);
    for (int i = 0; i < count; i++) byte_arr[i] = pattern(mode, i, v);
  endtask

  task automatic push_exp(input int count, input int mode, input logic [7:0] v);
    for (int i = 0; i < count; i++) exp_q.push_back(pattern(mode, i, v));
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    window_valid = 1'b0;
    flush        = 1'b0;
    sample_ready = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    check("rst_window_ready", 32'(window_ready), 32'd1);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_sample_data", 32'(sample_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
  endtask

  task automatic send_bytes(input int count, input int toggle_at);
    for (int i = 0; i < count; i++) begin
      int guard;
      guard = 0;
      while (!window_ready && guard < 600) begin
        tick();
        guard++;
      end
      if (guard >= 600) check("window_ready_timeout", 32'(window_ready), 32'd1);
      if (i == toggle_at) use_256_points = ~use_256_points;
      window_valid = 1'b1;
      window_data  = byte_arr[i];
      tick();
    end
    window_valid = 1'b0;
  endtask

  task automatic send_frame(input int count, input int toggle_at);
    send_bytes(count, toggle_at);
    check("latency_sample_valid", 32'(sample_valid), 32'd1);
    check("emit_window_ready", 32'(window_ready), 32'd0);
  endtask

  task automatic wait_done(input logic [7:0] exp_count);
    int cyc;
    cyc = 0;
    while (!frame_done && cyc < 600) begin
      tick();
      cyc++;
    end
    check("frame_done_seen", 32'(frame_done), 32'd1);
    check("frame_count", 32'(frame_count), 32'(exp_count));
    check("ready_after_done", 32'(window_ready), 32'd1);
    check("valid_after_done", 32'(sample_valid), 32'd0);
    tick();
    check("frame_done_pulse", 32'(frame_done), 32'd0);
    check("no_lost_samples", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    use_256_points      = 1'b0;
    overlap_half_window = 1'b0;
    window_data         = 8'd0;
    do_reset();

    // N=128 ramp, no overlap.
    fill(128, 1, 8'd0);
    push_exp(128, 1, 8'd0);
    send_frame(128, -1);
    check("state_emit", 32'(dbg_state), 32'(EMIT));
    wait_done(8'd1);
    check("done_once", 32'(done_cnt), 32'd1);

    // N=256 overlap: A all 0x10, then B all 0x30 averaging to 0x20.
    do_reset();
    done_cnt            = 0;
    use_256_points      = 1'b1;
    overlap_half_window = 1'b1;
    fill(256, 0, 8'h10);
    push_exp(128, 0, 8'h10);
    send_frame(256, -1);
    wait_done(8'd1);
    fill(256, 0, 8'h30);
    push_exp(128, 0, 8'h20);
    send_frame(256, -1);
    wait_done(8'd2);

    // Tail 0x30 with head 0xFF -> 0x98, then tail 0xFF with head 0xFE -> 0xFF.
    fill(256, 0, 8'hFF);
    push_exp(128, 0, 8'h98);
    send_frame(256, -1);
    wait_done(8'd3);
    fill(256, 0, 8'hFE);
    push_exp(128, 0, 8'hFF);
    send_frame(256, -1);
    wait_done(8'd4);

    // Backpressure for 5 cycles in the middle of a descending frame.
    use_256_points      = 1'b0;
    overlap_half_window = 1'b0;
    fill(128, 2, 8'd0);
    push_exp(128, 2, 8'd0);
    send_frame(128, -1);
    repeat (20) tick();
    sample_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_data", 32'(sample_data), 32'h0EB);
      check("stall_valid", 32'(sample_valid), 32'd1);
      check("stall_window_ready", 32'(window_ready), 32'd0);
    end
    sample_ready = 1'b1;
    wait_done(8'd5);

    // Overlap N=128: build a valid tail, flush a partial frame, then 0x55 frame.
    overlap_half_window = 1'b1;
    fill(128, 0, 8'h11);
    push_exp(64, 0, 8'h11);
    send_frame(128, -1);
    wait_done(8'd6);
    fill(60, 0, 8'h99);
    send_bytes(60, -1);
    flush        = 1'b1;
    window_valid = 1'b1;
    window_data  = 8'h77;
    tick();
    flush        = 1'b0;
    window_valid = 1'b0;
    fill(128, 0, 8'h55);
    push_exp(64, 0, 8'h55);
    send_frame(128, -1);
    wait_done(8'd7);

    // Size select toggled after byte 10: frame still completes at 128.
    overlap_half_window = 1'b0;
    use_256_points      = 1'b0;
    fill(128, 3, 8'd0);
    push_exp(128, 3, 8'd0);
    send_frame(128, 10);
    wait_done(8'd8);
    check("done_total", 32'(done_cnt), 32'd8);

    // Reset in the middle of an emit abandons the frame.
    use_256_points = 1'b0;
    fill(128, 1, 8'd0);
    push_exp(128, 1, 8'd0);
    send_frame(128, -1);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_sample_valid", 32'(sample_valid), 32'd0);
    check("mid_rst_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    check("post_rst_window_ready", 32'(window_ready), 32'd1);
    repeat (10) tick();
    check("post_rst_frame_done", 32'(frame_done), 32'd0);
    check("post_rst_done_total", 32'(done_cnt), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
